// File: rtl/pe_out_drain.sv
// pe_out_drain: captures finished PE-array output tiles into two ping-pong
// banks and streams them out one row per beat over valid/ready. Tiles that
// arrive while both banks are full are dropped and counted.
module pe_out_drain #(
    parameter int COL   = 16,
    parameter int ROW   = 2,
    parameter int DW    = 16,
    parameter int TAG_W = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    input  logic [ROW*COL*DW-1:0]                     in_data,
    input  logic [TAG_W-1:0]                          in_tag,
    output logic                                      in_ready,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [COL*DW-1:0]                         out_data,
    output logic [((ROW > 1) ? $clog2(ROW) : 1)-1:0]  out_row,
    output logic [TAG_W-1:0]                          out_tag,
    output logic                                      out_last,
    input  logic                                      ovf_clr,
    output logic                                      overflow,
    output logic [7:0]                                drop_cnt
);

    localparam int RW        = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int ROW_BITS  = COL * DW;
    localparam int TILE_BITS = ROW * ROW_BITS;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROW - 1);

    logic [TILE_BITS-1:0] bank [2];
    logic [TAG_W-1:0]     tag  [2];
    logic [1:0]           count;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [RW-1:0]        row_idx;

    logic                 capture;
    logic                 drop;
    logic                 accept;
    logic                 release_beat;
    logic [TILE_BITS-1:0] head_tile;

    // The array never stalls, so in_ready is status only: a tile arriving
    // while both banks are occupied is lost, even if a bank frees this cycle.
    assign in_ready     = (count != 2'd2);
    assign capture      = in_valid && in_ready;
    assign drop         = in_valid && !in_ready;
    assign out_valid    = (count != 2'd0);
    assign accept       = out_valid && out_ready;
    assign out_last     = (row_idx == LAST_ROW);
    assign release_beat = accept && out_last;
    assign head_tile    = bank[rd_ptr];
    assign out_row      = row_idx;
    assign out_tag      = tag[rd_ptr];

    // Select the current row of the head tile; stays stable while stalled.
    always_comb begin
        out_data = '0;
        for (int r = 0; r < ROW; r++) begin
            if (row_idx == RW'(r)) begin
                out_data = head_tile[r*ROW_BITS +: ROW_BITS];
            end
        end
    end

    // Bank storage, ping-pong pointers, occupancy, row walk and drop tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank[0]  <= '0;
            bank[1]  <= '0;
            tag[0]   <= '0;
            tag[1]   <= '0;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            row_idx  <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            if (capture) begin
                bank[wr_ptr] <= in_data;
                tag[wr_ptr]  <= in_tag;
                wr_ptr       <= ~wr_ptr;
            end

            if (accept) begin
                if (out_last) begin
                    row_idx <= '0;
                    rd_ptr  <= ~rd_ptr;
                end else begin
                    row_idx <= row_idx + RW'(1);
                end
            end

            case ({capture, release_beat})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (ovf_clr) begin
                overflow <= drop;
                drop_cnt <= drop ? 8'd1 : 8'd0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_out_drain.sv
// tb_pe_out_drain: directed bench for pe_out_drain with hand-computed tiles.
module tb_pe_out_drain;

    localparam int COL   = 16;
    localparam int ROW   = 2;
    localparam int DW    = 16;
    localparam int TAG_W = 1;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic [ROW*COL*DW-1:0] in_data;
    logic [TAG_W-1:0]      in_tag;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [COL*DW-1:0]     out_data;
    logic [0:0]            out_row;
    logic [TAG_W-1:0]      out_tag;
    logic                  out_last;
    logic                  ovf_clr;
    logic                  overflow;
    logic [7:0]            drop_cnt;

    int check_count;
    int fail_count;

    pe_out_drain #(.COL(COL), .ROW(ROW), .DW(DW), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_tag   (out_tag),
        .out_last  (out_last),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tile whose element [r][c] is base + r*256 + c.
    function automatic logic [ROW*COL*DW-1:0] make_tile(input logic [15:0] base);
        logic [ROW*COL*DW-1:0] t;
        t = '0;
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                t[(r*COL+c)*DW +: DW] = base + 16'(r*256 + c);
        return t;
    endfunction

    // Expected row r of a tile built by make_tile(base).
    function automatic logic [COL*DW-1:0] exp_row(input logic [15:0] base, input int r);
        logic [COL*DW-1:0] v;
        v = '0;
        for (int c = 0; c < COL; c++)
            v[c*DW +: DW] = base + 16'(r*256 + c);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] observed,
                               input logic [255:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] base, input logic [TAG_W-1:0] t);
        in_valid = v;
        in_data  = make_tile(base);
        in_tag   = t;
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
        checkOutput("rst_in_ready",  256'(in_ready),  256'(1));
        checkOutput("rst_overflow",  256'(overflow),  256'(0));
        checkOutput("rst_drop_cnt",  256'(drop_cnt),  256'(0));
        checkOutput("rst_out_row",   256'(out_row),   256'(0));
        checkOutput("rst_out_tag",   256'(out_tag),   256'(0));
        checkOutput("rst_out_last",  256'(out_last),  256'(0));
        checkOutput("rst_out_data",  256'(out_data),  256'(0));

        // 1: single tile, consumer always ready
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h0000, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput("t1_valid0", 256'(out_valid), 256'(1));
        checkOutput("t1_row0",   256'(out_row),   256'(0));
        checkOutput("t1_lane5a", 256'(out_data[5*DW +: DW]), 256'(16'h0005));
        checkOutput("t1_last0",  256'(out_last),  256'(0));
        tick();
        checkOutput("t1_row1",   256'(out_row),   256'(1));
        checkOutput("t1_lane5b", 256'(out_data[5*DW +: DW]), 256'(16'h0105));
        checkOutput("t1_last1",  256'(out_last),  256'(1));
        checkOutput("t1_tag",    256'(out_tag),   256'(1));
        tick();
        checkOutput("t1_empty",  256'(out_valid), 256'(0));

        // 2: two tiles under back-pressure, then drain in order
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h1000, 1'b0);
        tick();
        checkOutput("t2_ready_one", 256'(in_ready), 256'(1));
        applyStimulus(1'b1, 16'h2000, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput("t2_ready_full", 256'(in_ready), 256'(0));
        for (int i = 0; i < 10; i++) begin
            checkOutput("t2_hold_data", out_data, exp_row(16'h1000, 0));
            checkOutput("t2_hold_valid", 256'(out_valid), 256'(1));
            tick();
        end
        out_ready = 1'b1;
        checkOutput("t2_A0", out_data, exp_row(16'h1000, 0));
        checkOutput("t2_A0_tag", 256'(out_tag), 256'(0));
        tick();
        checkOutput("t2_A1", out_data, exp_row(16'h1000, 1));
        checkOutput("t2_A1_last", 256'(out_last), 256'(1));
        tick();
        checkOutput("t2_B0", out_data, exp_row(16'h2000, 0));
        checkOutput("t2_B0_tag", 256'(out_tag), 256'(1));
        checkOutput("t2_B0_row", 256'(out_row), 256'(0));
        tick();
        checkOutput("t2_B1", out_data, exp_row(16'h2000, 1));
        tick();
        checkOutput("t2_empty", 256'(out_valid), 256'(0));

        // 3: three drops while full, then clear
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h3000, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h4000, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h5000, 1'b0);
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        checkOutput("t3_overflow", 256'(overflow), 256'(1));
        checkOutput("t3_drop_cnt", 256'(drop_cnt), 256'(3));
        checkOutput("t3_data_kept", out_data, exp_row(16'h3000, 0));
        checkOutput("t3_tag_kept", 256'(out_tag), 256'(0));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checkOutput("t3_clr_ovf", 256'(overflow), 256'(0));
        checkOutput("t3_clr_cnt", 256'(drop_cnt), 256'(0));

        // 4: full, incoming tile coincides with last-row release -> dropped
        out_ready = 1'b1;
        tick();
        checkOutput("t4_last_row", 256'(out_last), 256'(1));
        applyStimulus(1'b1, 16'h6000, 1'b0);
        tick();
        in_valid = 1'b0;
        checkOutput("t4_drop_cnt", 256'(drop_cnt), 256'(1));
        checkOutput("t4_in_ready", 256'(in_ready), 256'(1));
        checkOutput("t4_D0", out_data, exp_row(16'h4000, 0));
        checkOutput("t4_D0_tag", 256'(out_tag), 256'(1));

        // 5: one tile, capture on its last-row accept -> count stays 1
        tick();
        checkOutput("t5_D1", out_data, exp_row(16'h4000, 1));
        applyStimulus(1'b1, 16'h7000, 1'b0);
        tick();
        in_valid = 1'b0;
        checkOutput("t5_valid", 256'(out_valid), 256'(1));
        checkOutput("t5_in_ready", 256'(in_ready), 256'(1));
        checkOutput("t5_G0", out_data, exp_row(16'h7000, 0));
        checkOutput("t5_G0_tag", 256'(out_tag), 256'(0));
        checkOutput("t5_G0_row", 256'(out_row), 256'(0));
        tick();
        checkOutput("t5_G1", out_data, exp_row(16'h7000, 1));
        tick();
        checkOutput("t5_empty", 256'(out_valid), 256'(0));

        // 6: reset mid-drain, then saturate the drop counter
        applyStimulus(1'b1, 16'h8000, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("t6_mid_row", 256'(out_row), 256'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 256'(out_valid), 256'(0));
        checkOutput("t6_rst_row", 256'(out_row), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("t6_post_ready", 256'(in_ready), 256'(1));
        checkOutput("t6_post_row", 256'(out_row), 256'(0));
        checkOutput("t6_post_valid", 256'(out_valid), 256'(0));
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h9000, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        checkOutput("t6_sat_cnt", 256'(drop_cnt), 256'(255));
        checkOutput("t6_sat_ovf", 256'(overflow), 256'(1));
        checkOutput("t6_sat_data", out_data, exp_row(16'h9000, 0));
        ovf_clr  = 1'b1;
        in_valid = 1'b1;
        tick();
        ovf_clr  = 1'b0;
        in_valid = 1'b0;
        checkOutput("t6_clr_drop_ovf", 256'(overflow), 256'(1));
        checkOutput("t6_clr_drop_cnt", 256'(drop_cnt), 256'(1));

        $display("%0d/%0d checks passed", check_count - fail_count, check_count);
        $finish;
    end

endmodule
